// File: rtl/calc_pkg.sv
// Address/select width helpers derived from the panel geometry.
package calc_pkg;
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : 32'($clog2(v));
  endfunction

  function automatic int unsigned num_row_address_bits(input int unsigned pixel_height);
    return clog2_min1(pixel_height);
  endfunction

  function automatic int unsigned num_column_address_bits(input int unsigned pixel_width);
    return clog2_min1(pixel_width);
  endfunction

  function automatic int unsigned num_pixelcolorselect_bits(input int unsigned bytes_per_pixel);
    return clog2_min1(bytes_per_pixel);
  endfunction
endpackage

// File: rtl/params_pkg.sv
// Default panel geometry shared by the display pipeline.
package params_pkg;
  localparam int unsigned BYTES_PER_PIXEL = 3;
  localparam int unsigned PIXEL_HEIGHT    = 32;
  localparam int unsigned PIXEL_WIDTH     = 64;
endpackage

// File: rtl/control_cmd_dispatch.sv
// Command dispatcher: decodes an opcode byte, streams the payload to one subcommand
// engine, muxes that engine's RAM bus and aborts it after an inter-byte timeout.
module control_cmd_dispatch #(
  parameter int unsigned BYTES_PER_PIXEL = params_pkg::BYTES_PER_PIXEL,
  parameter int unsigned PIXEL_HEIGHT    = params_pkg::PIXEL_HEIGHT,
  parameter int unsigned PIXEL_WIDTH     = params_pkg::PIXEL_WIDTH,
  parameter int unsigned NUM_SUBCMD      = 4,
  parameter logic [7:0]  OPCODE_BASE     = 8'h41,
  parameter int unsigned TIMEOUT_CYCLES  = 4096,
  parameter int unsigned _UNUSED         = 0,
  localparam int unsigned RB = calc_pkg::num_row_address_bits(PIXEL_HEIGHT),
  localparam int unsigned CB = calc_pkg::num_column_address_bits(PIXEL_WIDTH),
  localparam int unsigned PB = calc_pkg::num_pixelcolorselect_bits(BYTES_PER_PIXEL),
  localparam int unsigned N  = NUM_SUBCMD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      data_in,
  input  logic            enable,
  output logic [N-1:0]    sub_enable,
  output logic [7:0]      sub_data,
  output logic [N-1:0]    sub_reset,
  input  logic [N-1:0]    sub_done,
  input  logic [N-1:0]    sub_we,
  input  logic [N-1:0]    sub_as,
  input  logic [N*RB-1:0] sub_row,
  input  logic [N*CB-1:0] sub_col,
  input  logic [N*PB-1:0] sub_pixel,
  input  logic [N*8-1:0]  sub_do,
  output logic [RB-1:0]   row,
  output logic [CB-1:0]   column,
  output logic [PB-1:0]   pixel,
  output logic [7:0]      data_out,
  output logic            ram_write_enable,
  output logic            ram_access_start,
  output logic            busy,
  output logic            cmd_done,
  output logic            cmd_error
);

  localparam int unsigned SEL_W   = (N > 1) ? 32'($clog2(N)) : 1;
  localparam int unsigned TO_BITS = 32'($clog2(TIMEOUT_CYCLES));
  // _UNUSED has no effect on the hardware.
  localparam int unsigned WD_W    = ((TO_BITS > 16) ? TO_BITS : 16) + (_UNUSED & 0);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               cmd_done_q, cmd_done_d;
  logic               cmd_error_q, cmd_error_d;
  logic               busy_q, busy_d;
  logic [N-1:0]       sub_reset_q, sub_reset_d;
  logic [7:0]         idx;
  logic               done_sel;

  logic [N-1:0]       sub_enable_c;
  logic [RB-1:0]      row_c;
  logic [CB-1:0]      column_c;
  logic [PB-1:0]      pixel_c;
  logic [7:0]         data_out_c;
  logic               we_c;
  logic               as_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      wd_q        <= '0;
      cmd_done_q  <= 1'b0;
      cmd_error_q <= 1'b0;
      busy_q      <= 1'b0;
      sub_reset_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      wd_q        <= wd_d;
      cmd_done_q  <= cmd_done_d;
      cmd_error_q <= cmd_error_d;
      busy_q      <= busy_d;
      sub_reset_q <= sub_reset_d;
    end
  end

  // Next state: opcode decode, completion, watchdog and one-cycle abort.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    wd_d        = wd_q;
    cmd_done_d  = 1'b0;
    cmd_error_d = 1'b0;
    sub_reset_d = '0;
    idx         = data_in - OPCODE_BASE;
    done_sel    = sub_done[sel_q];
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (enable) begin
          if (32'(idx) < N) begin
            sel_d   = SEL_W'(idx);
            state_d = BUSY;
          end else begin
            cmd_error_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (done_sel) begin
          state_d    = IDLE;
          cmd_done_d = 1'b1;
          wd_d       = '0;
        end else if (enable) begin
          wd_d = '0;
        end else if (wd_q >= WD_LIMIT) begin
          state_d            = ABORT;
          cmd_error_d        = 1'b1;
          sub_reset_d[sel_q] = 1'b1;
          wd_d               = '0;
        end else if (wd_q != '1) begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ABORT: begin
        state_d = IDLE;
        wd_d    = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Byte strobe and RAM bus follow the selected engine only while BUSY.
  always_comb begin
    sub_enable_c = '0;
    row_c        = '0;
    column_c     = '0;
    pixel_c      = '0;
    data_out_c   = '0;
    we_c         = 1'b0;
    as_c         = 1'b0;
    if (state_q == BUSY) begin
      sub_enable_c[sel_q] = enable & ~sub_done[sel_q];
      for (int i = 0; i < N; i++) begin
        if (sel_q == SEL_W'(i)) begin
          row_c      = sub_row[i*RB +: RB];
          column_c   = sub_col[i*CB +: CB];
          pixel_c    = sub_pixel[i*PB +: PB];
          data_out_c = sub_do[i*8 +: 8];
          we_c       = sub_we[i];
          as_c       = sub_as[i];
        end
      end
    end
  end

  assign sub_enable       = sub_enable_c;
  assign sub_data         = data_in;
  assign sub_reset        = sub_reset_q;
  assign row              = row_c;
  assign column           = column_c;
  assign pixel            = pixel_c;
  assign data_out         = data_out_c;
  assign ram_write_enable = we_c;
  assign ram_access_start = as_c;
  assign busy             = busy_q;
  assign cmd_done         = cmd_done_q;
  assign cmd_error        = cmd_error_q;

endmodule

// File: tb/tb_control_cmd_dispatch.sv
// Self-checking bench for control_cmd_dispatch: directed scenarios plus a random
// byte/done stream compared against a transaction-level reference model.
module tb_control_cmd_dispatch;
  localparam int unsigned N  = 4;
  localparam int unsigned TO = 16;
  localparam int unsigned RB = calc_pkg::num_row_address_bits(params_pkg::PIXEL_HEIGHT);
  localparam int unsigned CB = calc_pkg::num_column_address_bits(params_pkg::PIXEL_WIDTH);
  localparam int unsigned PB = calc_pkg::num_pixelcolorselect_bits(params_pkg::BYTES_PER_PIXEL);

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      data_in;
  logic            enable;
  logic [N-1:0]    sub_enable, sub_reset, sub_done, sub_we, sub_as;
  logic [7:0]      sub_data;
  logic [N*RB-1:0] sub_row;
  logic [N*CB-1:0] sub_col;
  logic [N*PB-1:0] sub_pixel;
  logic [N*8-1:0]  sub_do;
  logic [RB-1:0]   row;
  logic [CB-1:0]   column;
  logic [PB-1:0]   pixel;
  logic [7:0]      data_out;
  logic            ram_write_enable, ram_access_start, busy, cmd_done, cmd_error;

  int n_checks = 0;
  int n_fail   = 0;

  control_cmd_dispatch #(.NUM_SUBCMD(N), .OPCODE_BASE(8'h41), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .enable(enable),
    .sub_enable(sub_enable), .sub_data(sub_data), .sub_reset(sub_reset), .sub_done(sub_done),
    .sub_we(sub_we), .sub_as(sub_as), .sub_row(sub_row), .sub_col(sub_col),
    .sub_pixel(sub_pixel), .sub_do(sub_do), .row(row), .column(column), .pixel(pixel),
    .data_out(data_out), .ram_write_enable(ram_write_enable), .ram_access_start(ram_access_start),
    .busy(busy), .cmd_done(cmd_done), .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_engines();
    sub_done = '0; sub_we = '0; sub_as = '0;
    sub_row = '0; sub_col = '0; sub_pixel = '0; sub_do = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; data_in = '0;
    clear_engines();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; data_in = 8'h42;
    sub_done = '0; sub_we = '1; sub_as = '1;
    sub_row = '1; sub_col = '1; sub_pixel = '1; sub_do = '1;
    #1 reset = 1'b1;
    #1;
    n_checks++; if ({busy, cmd_done, cmd_error} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: busy/done/err=%b expected 000", {busy, cmd_done, cmd_error}); end
    n_checks++; if (sub_reset !== 4'b0000) begin n_fail++; $display("FAIL reset_sub_reset: got %b expected 0000", sub_reset); end
    n_checks++; if (sub_enable !== 4'b0000) begin n_fail++; $display("FAIL reset_sub_enable: got %b expected 0000", sub_enable); end
    n_checks++; if ({row, column, pixel, data_out, ram_write_enable, ram_access_start} !== '0) begin n_fail++; $display("FAIL reset_ram_mux: row=%h col=%h pix=%h do=%h we=%b as=%b expected all 0", row, column, pixel, data_out, ram_write_enable, ram_access_start); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_hold_busy: got %b expected 0", busy); end
    reset = 1'b0; enable = 1'b0; data_in = '0;
    clear_engines();
    tick();
    n_checks++; if ({busy, cmd_done, cmd_error} !== 3'b000) begin n_fail++; $display("FAIL reset_release: busy/done/err=%b expected 000", {busy, cmd_done, cmd_error}); end
  endtask

  task automatic test_happy_path();
    int dones = 0;
    enable = 1'b1; data_in = 8'h42;
    #1;
    n_checks++; if (sub_enable !== 4'b0000) begin n_fail++; $display("FAIL happy_opcode_fwd: sub_enable=%b expected 0000", sub_enable); end
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL happy_busy: got %b expected 1", busy); end
    for (int b = 0; b < 3; b++) begin
      enable = 1'b1; data_in = 8'($urandom);
      sub_done = (b == 1) ? 4'b0001 : 4'b0000;
      #1;
      n_checks++; if (sub_enable !== 4'b0010) begin n_fail++; $display("FAIL happy_payload%0d: sub_enable=%b expected 0010", b, sub_enable); end
      n_checks++; if (sub_data !== data_in) begin n_fail++; $display("FAIL happy_sub_data%0d: got %h expected %h", b, sub_data, data_in); end
      tick();
      dones += int'(cmd_done);
      sub_done = '0; enable = 1'b0;
      #1;
      n_checks++; if (sub_enable !== 4'b0000) begin n_fail++; $display("FAIL happy_gap%0d: sub_enable=%b expected 0000", b, sub_enable); end
      tick();
      dones += int'(cmd_done);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL happy_still_busy%0d: got %b expected 1", b, busy); end
    end
    sub_done = 4'b0010;
    tick();
    sub_done = '0;
    n_checks++; if ({cmd_done, cmd_error, busy} !== 3'b100) begin n_fail++; $display("FAIL happy_done: done/err/busy=%b expected 100", {cmd_done, cmd_error, busy}); end
    dones += int'(cmd_done);
    tick();
    dones += int'(cmd_done);
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL happy_done_count: got %0d expected 1", dones); end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] ops [2];
    ops[0] = 8'h45; ops[1] = 8'h40;
    for (int k = 0; k < 2; k++) begin
      enable = 1'b1; data_in = ops[k];
      #1;
      n_checks++; if (sub_enable !== 4'b0000) begin n_fail++; $display("FAIL bad_op_%h_fwd: sub_enable=%b expected 0000", ops[k], sub_enable); end
      tick();
      enable = 1'b0;
      n_checks++; if ({cmd_error, cmd_done, busy} !== 3'b100) begin n_fail++; $display("FAIL bad_op_%h: err/done/busy=%b expected 100", ops[k], {cmd_error, cmd_done, busy}); end
      tick();
      n_checks++; if ({cmd_error, busy} !== 2'b00) begin n_fail++; $display("FAIL bad_op_%h_after: err/busy=%b expected 00", ops[k], {cmd_error, busy}); end
    end
  endtask

  task automatic test_mux();
    enable = 1'b1; data_in = 8'h43;
    tick();
    enable = 1'b0;
    sub_we = 4'b0101; sub_as = 4'b0001;
    sub_row[0*RB +: RB] = RB'(7);     sub_row[2*RB +: RB] = RB'(3);
    sub_col[0*CB +: CB] = CB'(1);     sub_col[2*CB +: CB] = CB'(5);
    sub_pixel[0*PB +: PB] = PB'(1);   sub_pixel[2*PB +: PB] = PB'(2);
    sub_do[0*8 +: 8] = 8'h5A;         sub_do[2*8 +: 8] = 8'hA5;
    #1;
    n_checks++; if ({row, column, pixel, data_out} !== {RB'(3), CB'(5), PB'(2), 8'hA5}) begin n_fail++; $display("FAIL mux_busy_bus: row=%0d col=%0d pix=%0d do=%h expected 3 5 2 a5", row, column, pixel, data_out); end
    n_checks++; if ({ram_write_enable, ram_access_start} !== 2'b10) begin n_fail++; $display("FAIL mux_busy_strobes: we/as=%b expected 10", {ram_write_enable, ram_access_start}); end
    sub_done = 4'b0100;
    tick();
    sub_done = '0;
    n_checks++; if (cmd_done !== 1'b1) begin n_fail++; $display("FAIL mux_done: got %b expected 1", cmd_done); end
    n_checks++; if ({row, column, pixel, data_out, ram_write_enable, ram_access_start} !== '0) begin n_fail++; $display("FAIL mux_idle_zero: row=%h col=%h pix=%h do=%h we=%b as=%b expected all 0", row, column, pixel, data_out, ram_write_enable, ram_access_start); end
    clear_engines();
    tick();
  endtask

  task automatic test_timeout();
    int early = 0;
    enable = 1'b1; data_in = 8'h41;
    tick();
    enable = 1'b0;
    for (int k = 1; k < TO; k++) begin
      tick();
      if ({busy, cmd_error, sub_reset} !== {1'b1, 1'b0, 4'b0000}) early++;
    end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL timeout_early: %0d premature cycles expected 0", early); end
    tick();
    n_checks++; if (sub_reset !== 4'b0001) begin n_fail++; $display("FAIL timeout_sub_reset: got %b expected 0001", sub_reset); end
    n_checks++; if ({cmd_error, cmd_done, busy} !== 3'b101) begin n_fail++; $display("FAIL timeout_abort: err/done/busy=%b expected 101", {cmd_error, cmd_done, busy}); end
    enable = 1'b1; data_in = 8'h41;
    tick();
    enable = 1'b0;
    n_checks++; if ({busy, cmd_error, sub_reset} !== {1'b0, 1'b0, 4'b0000}) begin n_fail++; $display("FAIL timeout_after: busy/err/sub_reset=%b expected 0_0_0000", {busy, cmd_error, sub_reset}); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_enable_dropped: busy=%b expected 0", busy); end
  endtask

  task automatic test_collisions();
    enable = 1'b1; data_in = 8'h42;
    tick();
    data_in = 8'h11;
    #1;
    n_checks++; if (sub_enable !== 4'b0010) begin n_fail++; $display("FAIL coll_payload: sub_enable=%b expected 0010", sub_enable); end
    tick();
    data_in = 8'h41; sub_done = 4'b0010;
    #1;
    n_checks++; if (sub_enable !== 4'b0000) begin n_fail++; $display("FAIL coll_dropped_fwd: sub_enable=%b expected 0000", sub_enable); end
    tick();
    enable = 1'b0; sub_done = '0;
    n_checks++; if ({cmd_done, cmd_error, busy} !== 3'b100) begin n_fail++; $display("FAIL coll_done: done/err/busy=%b expected 100", {cmd_done, cmd_error, busy}); end
    tick();
    n_checks++; if ({busy, cmd_done} !== 2'b00) begin n_fail++; $display("FAIL coll_not_decoded: busy/done=%b expected 00", {busy, cmd_done}); end
    enable = 1'b1; data_in = 8'h41;
    tick();
    enable = 1'b0;
    repeat (TO - 1) tick();
    sub_done = 4'b0001;
    tick();
    sub_done = '0;
    n_checks++; if ({cmd_done, cmd_error, sub_reset, busy} !== {1'b1, 1'b0, 4'b0000, 1'b0}) begin n_fail++; $display("FAIL coll_timeout_done: done/err/sub_reset/busy=%b expected 1_0_0000_0", {cmd_done, cmd_error, sub_reset, busy}); end
    tick();
    n_checks++; if ({cmd_error, sub_reset} !== 5'b0) begin n_fail++; $display("FAIL coll_timeout_late: err/sub_reset=%b expected 0_0000", {cmd_error, sub_reset}); end
  endtask

  task automatic test_async_reset();
    enable = 1'b1; data_in = 8'h42;
    tick();
    data_in = 8'h99; sub_we = 4'b0010; sub_row[1*RB +: RB] = RB'(5);
    #1;
    n_checks++; if ({sub_enable, ram_write_enable} !== 5'b0010_1) begin n_fail++; $display("FAIL areset_pre: sub_enable/we=%b expected 0010_1", {sub_enable, ram_write_enable}); end
    #1 reset = 1'b1;
    #1;
    n_checks++; if ({sub_enable, ram_write_enable, row, busy} !== '0) begin n_fail++; $display("FAIL areset_immediate: sub_enable=%b we=%b row=%h busy=%b expected all 0", sub_enable, ram_write_enable, row, busy); end
    enable = 1'b0;
    tick();
    n_checks++; if ({cmd_done, cmd_error, sub_reset} !== 6'b0) begin n_fail++; $display("FAIL areset_pulses: done/err/sub_reset=%b expected 0_0_0000", {cmd_done, cmd_error, sub_reset}); end
    #1 reset = 1'b0;
    clear_engines();
    tick();
    n_checks++; if ({busy, cmd_done, cmd_error} !== 3'b000) begin n_fail++; $display("FAIL areset_release: busy/done/err=%b expected 000", {busy, cmd_done, cmd_error}); end
    enable = 1'b1; data_in = 8'h43;
    tick();
    data_in = 8'h77;
    #1;
    n_checks++; if ({busy, sub_enable} !== 5'b1_0100) begin n_fail++; $display("FAIL areset_first_opcode: busy/sub_enable=%b expected 1_0100", {busy, sub_enable}); end
    tick();
    enable = 1'b0; sub_done = 4'b0100;
    tick();
    sub_done = '0;
    n_checks++; if (cmd_done !== 1'b1) begin n_fail++; $display("FAIL areset_finish: cmd_done=%b expected 1", cmd_done); end
    tick();
  endtask

  // Reference model: a command is active from an accepted opcode until the
  // engine reports done or TO consecutive byte-less cycles elapse.
  task automatic test_random();
    bit           m_active = 0, m_abort = 0;
    int           m_sel = 0, m_quiet = 0, quiet_left = 0, idx;
    logic         e_done = 0, e_err = 0;
    logic [N-1:0] e_sreset = '0, x_en, nsr;
    logic [RB-1:0] x_row; logic [CB-1:0] x_col; logic [PB-1:0] x_pix; logic [7:0] x_do;
    logic         x_we, x_as, nd, ne;
    int           n_done = 0, n_abort = 0;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (quiet_left > 0) begin
        quiet_left--; enable = 1'b0; sub_done = '0;
      end else begin
        if ($urandom_range(0, 50) == 0) quiet_left = $urandom_range(12, 22);
        enable  = ($urandom_range(0, 2) == 0);
        data_in = ($urandom_range(0, 9) < 7) ? 8'(8'h41 + $urandom_range(0, 3)) : 8'($urandom);
        for (int i = 0; i < N; i++) sub_done[i] = ($urandom_range(0, 11) == 0);
      end
      sub_we = N'($urandom); sub_as = N'($urandom);
      sub_row = (N*RB)'({$urandom, $urandom}); sub_col = (N*CB)'({$urandom, $urandom});
      sub_pixel = (N*PB)'($urandom); sub_do = (N*8)'($urandom);
      #1;
      x_en = '0; x_row = '0; x_col = '0; x_pix = '0; x_do = '0; x_we = 0; x_as = 0;
      if (m_active) begin
        if (enable && !sub_done[m_sel]) x_en[m_sel] = 1'b1;
        x_row = sub_row[m_sel*RB +: RB]; x_col = sub_col[m_sel*CB +: CB];
        x_pix = sub_pixel[m_sel*PB +: PB]; x_do = sub_do[m_sel*8 +: 8];
        x_we = sub_we[m_sel]; x_as = sub_as[m_sel];
      end
      n_checks++; if (sub_enable !== x_en) begin n_fail++; $display("FAIL rnd_sub_enable cyc%0d: got %b expected %b", cyc, sub_enable, x_en); end
      n_checks++; if (sub_data !== data_in) begin n_fail++; $display("FAIL rnd_sub_data cyc%0d: got %h expected %h", cyc, sub_data, data_in); end
      n_checks++; if ({row, column, pixel, data_out, ram_write_enable, ram_access_start} !== {x_row, x_col, x_pix, x_do, x_we, x_as}) begin n_fail++; $display("FAIL rnd_ram_mux cyc%0d: got %h/%h/%h/%h/%b/%b expected %h/%h/%h/%h/%b/%b", cyc, row, column, pixel, data_out, ram_write_enable, ram_access_start, x_row, x_col, x_pix, x_do, x_we, x_as); end
      n_checks++; if ({busy, cmd_done, cmd_error, sub_reset} !== {(m_active || m_abort), e_done, e_err, e_sreset}) begin n_fail++; $display("FAIL rnd_status cyc%0d: busy/done/err/sub_reset=%b%b%b_%b expected %b%b%b_%b", cyc, busy, cmd_done, cmd_error, sub_reset, (m_active || m_abort), e_done, e_err, e_sreset); end
      n_checks++; if ((cmd_done & cmd_error) !== 1'b0) begin n_fail++; $display("FAIL rnd_done_and_error cyc%0d: both high", cyc); end
      nd = 0; ne = 0; nsr = '0;
      if (m_abort) begin
        m_abort = 0;
      end else if (!m_active) begin
        if (enable) begin
          idx = int'(data_in) - 'h41;
          if (idx >= 0 && idx < N) begin m_active = 1; m_sel = idx; m_quiet = 0; end
          else ne = 1;
        end
      end else if (sub_done[m_sel]) begin
        m_active = 0; nd = 1; n_done++;
      end else if (enable) begin
        m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet == TO) begin m_active = 0; m_abort = 1; ne = 1; nsr[m_sel] = 1'b1; n_abort++; end
      end
      e_done = nd; e_err = ne; e_sreset = nsr;
      tick();
    end
    enable = 1'b0; clear_engines();
    n_checks++; if (n_done == 0 || n_abort == 0) begin n_fail++; $display("FAIL rnd_coverage: dones=%0d aborts=%0d expected both nonzero", n_done, n_abort); end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; data_in = '0;
    clear_engines();
    test_reset();
    test_happy_path();
    test_bad_opcode();
    test_mux();
    test_timeout();
    test_collisions();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
